// File: rtl/id_ex_reg_pkg.sv
// Shared decode encodings and the control bundle carried from decode into execute.
// The control unit, the ID/EX register and the EX stage all import this package.
package id_ex_reg_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001,
        ALU_LUI  = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    localparam int REG_ADDR_W = 5;
    localparam int N_DATA     = 5;  // RD1, RD2, PC, PC+4, ImmExt
    localparam int N_ADDR     = 3;  // Rs1, Rs2, Rd

    typedef struct packed {
        logic       RegWrite;
        logic [3:0] ALUControl;
        logic       ALUSrc;
        logic       MemWrite;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic [1:0] ResultSrc;
        logic [2:0] AddressingControl;
    } ctrl_t;

    // A bubble writes nothing, redirects nothing and selects the ALU result.
    localparam ctrl_t CTRL_BUBBLE = '{
        RegWrite:          1'b0,
        ALUControl:        ALU_ADD,
        ALUSrc:            1'b0,
        MemWrite:          1'b0,
        branch:            1'b0,
        jump:              1'b0,
        jalr:              1'b0,
        ResultSrc:         RES_ALU,
        AddressingControl: 3'b000
    };

endpackage

// File: rtl/id_ex_reg_if.sv
// Decode-side inputs and execute-side outputs of the ID/EX pipeline register.
interface id_ex_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  validD, RegWriteD, MemWriteD, ALUSrcD, branchD, jumpD, jalrD;
    logic [3:0]            ALUControlD;
    logic [1:0]            ResultSrcD;
    logic [2:0]            AddressingControlD;
    logic [DATA_WIDTH-1:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
    logic [4:0]            Rs1D, Rs2D, RdD;

    logic                  validE, RegWriteE, MemWriteE, ALUSrcE, branchE, jumpE, jalrE;
    logic [3:0]            ALUControlE;
    logic [1:0]            ResultSrcE;
    logic [2:0]            AddressingControlE;
    logic [DATA_WIDTH-1:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
    logic [4:0]            Rs1E, Rs2E, RdE;

    modport master (
        output validD, RegWriteD, MemWriteD, ALUSrcD, branchD, jumpD, jalrD,
               ALUControlD, ResultSrcD, AddressingControlD,
               RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
        input  validE, RegWriteE, MemWriteE, ALUSrcE, branchE, jumpE, jalrE,
               ALUControlE, ResultSrcE, AddressingControlE,
               RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE
    );

    modport slave (
        input  validD, RegWriteD, MemWriteD, ALUSrcD, branchD, jumpD, jalrD,
               ALUControlD, ResultSrcD, AddressingControlD,
               RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
        output validE, RegWriteE, MemWriteE, ALUSrcE, branchE, jumpE, jalrE,
               ALUControlE, ResultSrcE, AddressingControlE,
               RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE
    );
endinterface

// File: rtl/id_ex_reg_pipe_reg.sv
// Generic pipeline register: async active-low reset, synchronous clear
// (takes priority over hold) and load enable.
module pipe_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= CLR_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: loads, holds on stallE, inserts a bubble on flushE
// and counts inserted bubbles with a saturating counter.
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stallE,
    input  logic                 flushE,
    id_ex_if.slave               bus,
    output logic [CNT_WIDTH-1:0] bubble_cnt
);
    logic                  w_load;
    ctrl_t                 w_ctrl_d, w_ctrl_e;
    logic [DATA_WIDTH-1:0] w_data_d [N_DATA];
    logic [DATA_WIDTH-1:0] w_data_e [N_DATA];
    logic [REG_ADDR_W-1:0] w_addr_d [N_ADDR];
    logic [REG_ADDR_W-1:0] w_addr_e [N_ADDR];
    logic [CNT_WIDTH-1:0]  r_bubble_cnt;

    assign w_load = ~stallE;

    assign w_ctrl_d = '{
        RegWrite:          bus.RegWriteD,
        ALUControl:        bus.ALUControlD,
        ALUSrc:            bus.ALUSrcD,
        MemWrite:          bus.MemWriteD,
        branch:            bus.branchD,
        jump:              bus.jumpD,
        jalr:              bus.jalrD,
        ResultSrc:         bus.ResultSrcD,
        AddressingControl: bus.AddressingControlD
    };

    pipe_reg #(.WIDTH(1), .CLR_VAL(1'b0)) u_valid (
        .clk(clk), .rst_n(rst_n), .i_en(w_load), .i_clr(flushE),
        .i_d(bus.validD), .o_q(bus.validE)
    );

    pipe_reg #(.WIDTH($bits(ctrl_t)), .CLR_VAL(CTRL_BUBBLE)) u_ctrl (
        .clk(clk), .rst_n(rst_n), .i_en(w_load), .i_clr(flushE),
        .i_d(w_ctrl_d), .o_q(w_ctrl_e)
    );

    assign bus.RegWriteE          = w_ctrl_e.RegWrite;
    assign bus.ALUControlE        = w_ctrl_e.ALUControl;
    assign bus.ALUSrcE            = w_ctrl_e.ALUSrc;
    assign bus.MemWriteE          = w_ctrl_e.MemWrite;
    assign bus.branchE            = w_ctrl_e.branch;
    assign bus.jumpE              = w_ctrl_e.jump;
    assign bus.jalrE              = w_ctrl_e.jalr;
    assign bus.ResultSrcE         = w_ctrl_e.ResultSrc;
    assign bus.AddressingControlE = w_ctrl_e.AddressingControl;

    assign w_data_d[0] = bus.RD1D;
    assign w_data_d[1] = bus.RD2D;
    assign w_data_d[2] = bus.PCD;
    assign w_data_d[3] = bus.PCPlus4D;
    assign w_data_d[4] = bus.ImmExtD;

    genvar gi;
    generate
        for (gi = 0; gi < N_DATA; gi++) begin : g_data
            pipe_reg #(.WIDTH(DATA_WIDTH)) u_data (
                .clk(clk), .rst_n(rst_n), .i_en(w_load), .i_clr(flushE),
                .i_d(w_data_d[gi]), .o_q(w_data_e[gi])
            );
        end
        for (gi = 0; gi < N_ADDR; gi++) begin : g_addr
            pipe_reg #(.WIDTH(REG_ADDR_W)) u_addr (
                .clk(clk), .rst_n(rst_n), .i_en(w_load), .i_clr(flushE),
                .i_d(w_addr_d[gi]), .o_q(w_addr_e[gi])
            );
        end
    endgenerate

    assign bus.RD1E     = w_data_e[0];
    assign bus.RD2E     = w_data_e[1];
    assign bus.PCE      = w_data_e[2];
    assign bus.PCPlus4E = w_data_e[3];
    assign bus.ImmExtE  = w_data_e[4];

    assign w_addr_d[0] = bus.Rs1D;
    assign w_addr_d[1] = bus.Rs2D;
    assign w_addr_d[2] = bus.RdD;
    assign bus.Rs1E    = w_addr_e[0];
    assign bus.Rs2E    = w_addr_e[1];
    assign bus.RdE     = w_addr_e[2];

    // Flush wins over stall, so a flush always counts even while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (flushE && (r_bubble_cnt != {CNT_WIDTH{1'b1}})) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter DATA_WIDTH, default 32, datapath word width.
REQ-002 Parameter CNT_WIDTH, default 32, bubble-counter width.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 stallE  input  1  hold all E-side state this cycle.
REQ-006 flushE  input  1  replace the incoming instruction with a bubble.
REQ-007 validD  input  1  D-side slot holds a real instruction.
REQ-008 RegWriteD, MemWriteD, ALUSrcD, branchD, jumpD, jalrD  input  1 each  decoded controls.
REQ-009 ALUControlD  input  4; ResultSrcD  input  2; AddressingControlD  input  3.
REQ-010 RD1D, RD2D, PCD, PCPlus4D, ImmExtD  input  DATA_WIDTH each  operands, PC, PC+4, extended immediate.
REQ-011 Rs1D, Rs2D, RdD  input  5 each  register addresses.
REQ-012 Each D input has a registered E output of equal width (validE, RegWriteE ... RdE).
REQ-013 bubble_cnt  output  CNT_WIDTH  number of bubbles inserted since reset.

Function
REQ-014 The block SHALL have a latency of exactly one clock: an input accepted at edge N SHALL appear on the E outputs after edge N.
REQ-015 Update priority per edge SHALL be: reset > flushE > stallE > load.
REQ-016 Load (flushE=0, stallE=0): every E output SHALL take its D input.
REQ-017 Stall (flushE=0, stallE=1): every E output, including bubble_cnt, SHALL hold its value.
REQ-018 Flush (flushE=1, regardless of stallE): validE, RegWriteE, MemWriteE, branchD->branchE, jumpE, jalrE SHALL become 0.
REQ-019 On flush, ALUControlE SHALL become 4'b0000, ResultSrcE 2'b00, AddressingControlE 3'b000, ALUSrcE 0, and all data and address outputs SHALL become 0.
REQ-020 A bubble SHALL NOT write the register file or memory, and SHALL NOT redirect the PC.
REQ-021 bubble_cnt SHALL increment by 1 on every flush edge and saturate at all-ones (no wrap).
REQ-022 Simultaneous flushE=1 and stallE=1 SHALL act as a flush and SHALL increment bubble_cnt.
REQ-023 Control fields SHALL pass through unmodified: no re-decode and no width change.
REQ-024 The block SHALL NOT gate on validD; an invalid D slot loads as given, with validE=0.

Reset
REQ-025 While rst_n=0, all E outputs and bubble_cnt SHALL be 0, asynchronously, independent of clk.
REQ-026 Reset SHALL override flushE and stallE.
REQ-027 After rst_n deasserts, the first rising edge SHALL follow REQ-015 priority.
REQ-028 Reset asserted mid-stall SHALL discard the held instruction; the held instruction SHALL NOT reappear after release.

Structure
REQ-029 The ALU op encodings, ResultSrc encodings (00 ALU, 01 memory, 10 PC+4) and the bubble control value SHALL live in a shared package used by the control unit, this block and the EX stage.
REQ-030 A packed control-bundle typedef (RegWrite, ALUControl, ALUSrc, MemWrite, branch, jump, jalr, ResultSrc, AddressingControl) SHALL be defined in the same package.
REQ-031 One generic sub-module, pipe_reg (parameterised width, async active-low reset, enable, synchronous clear), SHALL implement each field group.

Verification
REQ-032 Load: at edge 1, drive addi-style controls (RegWriteD=1, ALUSrcD=1, ALUControlD=0000), RD1D=0x10, ImmExtD=0x5, RdD=3 -> after edge 1, identical E values and validE=1.
REQ-033 Stall: load PCD=0x100, then stallE=1 for 3 edges while PCD=0x104 -> PCE stays 0x100 for 3 cycles, then becomes 0x104 on the next unstalled edge.
REQ-034 Flush: jal controls (jumpD=1, ResultSrcD=10) with flushE=1 -> jumpE=0, RegWriteE=0, ResultSrcE=00, validE=0, bubble_cnt=1.
REQ-035 Flush plus stall: flushE=1 and stallE=1 with MemWriteD=1 -> MemWriteE=0 and bubble_cnt increments.
REQ-036 Saturation: with CNT_WIDTH=4, apply 17 flushes -> bubble_cnt=4'hF.
REQ-037 Async reset: drop rst_n between edges during a stall holding RegWriteE=1 -> all outputs 0 immediately; after release, outputs stay 0 until the next load.
